// File: rtl/w0_bridge_pkg.sv
// Shared types and helpers for the W1-to-W0 coefficient bridge.
package w0_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        QUANT = 2'd2,
        SEND  = 2'd3
    } state_t;

    // W0 LUT encoding of the four levels when CODE_W = 2
    localparam logic [1:0] CODE_NEG3 = 2'b00;
    localparam logic [1:0] CODE_POS3 = 2'b01;
    localparam logic [1:0] CODE_NEG1 = 2'b10;
    localparam logic [1:0] CODE_POS1 = 2'b11;

    function automatic int map_src_idx(int dst_idx, int idx_offset, int ratio_log2, int n_src);
        int s;
        s = (dst_idx + idx_offset) >> ratio_log2;
        return (s > n_src - 1) ? n_src - 1 : s;
    endfunction

endpackage

// File: rtl/w0_coeff_bridge_ef_quantizer.sv
// Combinational nearest-odd quantiser with level clip, saturating
// error-feedback output and code encoder.
module ef_quantizer
    import w0_bridge_pkg::*;
#(
    parameter int COEFF_W = 24,
    parameter int R_COEFF = 20,
    parameter int SHIFT   = 5,
    parameter int CODE_W  = 2,
    parameter int ERR_W   = COEFF_W + 2
) (
    input  logic signed [COEFF_W-1:0] coeff,
    input  logic signed [ERR_W-1:0]   err_in,
    input  logic                      ns_en,
    output logic [CODE_W-1:0]         code,
    output logic signed [ERR_W-1:0]   err_out
);
    localparam int V_W = ERR_W + 1;
    localparam int D_W = ERR_W + 2;

    logic signed [COEFF_W-1:0] x;
    logic signed [ERR_W-1:0]   err_term;
    logic signed [V_W-1:0]     v;
    logic signed [V_W-1:0]     k;
    logic signed [CODE_W-1:0]  k_c;
    logic signed [D_W-1:0]     lvl_fix;
    logic signed [D_W-1:0]     diff;

    // The chosen level is L = 2k+1 with k = floor(v/2); clipping L to
    // +-(2^CODE_W-1) is exactly clipping k to a CODE_W-bit signed range.
    always_comb begin
        x        = coeff >>> SHIFT;
        err_term = ns_en ? err_in : '0;
        v        = V_W'(x) + V_W'(err_term);
        k        = v >>> (R_COEFF + 1);
        if (&k[V_W-1:CODE_W-1] || ~|k[V_W-1:CODE_W-1])
            k_c = k[CODE_W-1:0];
        else if (k[V_W-1])
            k_c = {1'b1, {(CODE_W-1){1'b0}}};
        else
            k_c = {1'b0, {(CODE_W-1){1'b1}}};
        lvl_fix = ((D_W'(k_c) <<< 1) + D_W'(1)) <<< R_COEFF;
        diff    = D_W'(v) - lvl_fix;
        if (&diff[D_W-1:ERR_W-1] || ~|diff[D_W-1:ERR_W-1])
            err_out = diff[ERR_W-1:0];
        else if (diff[D_W-1])
            err_out = {1'b1, {(ERR_W-1){1'b0}}};
        else
            err_out = {1'b0, {(ERR_W-1){1'b1}}};
    end

    if (CODE_W == 2) begin : g_lut
        always_comb begin
            case (k_c)
                2'b10:   code = CODE_NEG3;
                2'b11:   code = CODE_NEG1;
                2'b00:   code = CODE_POS1;
                default: code = CODE_POS3;
            endcase
        end
    end else begin : g_offset
        // (L + 2^CODE_W - 1)/2 reduces to k + 2^(CODE_W-1)
        assign code = {~k_c[CODE_W-1], k_c[CODE_W-2:0]};
    end

endmodule

// File: rtl/w0_coeff_bridge.sv
// Sweeps adaptive W coefficients, maps destination taps to source taps,
// quantises them and streams codes to the W0 LUT.
//  state | meaning
//  IDLE  | waiting for en && (start || mode_cont)
//  READ  | read strobe for the mapped source tap
//  QUANT | capture coefficient, register code and index
//  SEND  | offer update to W0 until accepted
module w0_coeff_bridge
    import w0_bridge_pkg::*;
#(
    parameter int N_SRC      = 32,
    parameter int N_DST      = 1024,
    parameter int IDX_OFFSET = 17,
    parameter int COEFF_W    = 24,
    parameter int R_COEFF    = 20,
    parameter int SHIFT      = 5,
    parameter int CODE_W     = 2,
    parameter int ERR_W      = COEFF_W + 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       mode_cont,
    input  logic                       start,
    input  logic                       ns_en,
    output logic                       rd_en_out,
    output logic [$clog2(N_SRC)-1:0]   rd_idx_out,
    input  logic [COEFF_W-1:0]         rd_coeff_in,
    output logic                       upd_valid_out,
    input  logic                       upd_ready_in,
    output logic [$clog2(N_DST)-1:0]   upd_idx_out,
    output logic [CODE_W-1:0]          upd_code_out,
    output logic                       busy_out,
    output logic                       sweep_done_out,
    output logic [15:0]                sweep_cnt_out
);
    localparam int SRC_W      = $clog2(N_SRC);
    localparam int DST_W      = $clog2(N_DST);
    localparam int RATIO_LOG2 = $clog2(N_DST / N_SRC);

    state_t                   state, state_nxt;
    logic [DST_W-1:0]         dst_idx;
    logic signed [ERR_W-1:0]  err_q;
    logic signed [ERR_W-1:0]  q_err;
    logic [CODE_W-1:0]        q_code;
    logic                     last_tap;

    ef_quantizer #(
        .COEFF_W (COEFF_W),
        .R_COEFF (R_COEFF),
        .SHIFT   (SHIFT),
        .CODE_W  (CODE_W),
        .ERR_W   (ERR_W)
    ) u_quant (
        .coeff   (rd_coeff_in),
        .err_in  (err_q),
        .ns_en   (ns_en),
        .code    (q_code),
        .err_out (q_err)
    );

    assign last_tap = (dst_idx == DST_W'(N_DST - 1));

    always_comb begin
        state_nxt     = state;
        rd_en_out     = 1'b0;
        rd_idx_out    = '0;
        upd_valid_out = 1'b0;
        busy_out      = (state != IDLE);
        case (state)
            IDLE: if (en && (start || mode_cont)) state_nxt = READ;
            READ: begin
                rd_en_out  = 1'b1;
                rd_idx_out = SRC_W'(map_src_idx(32'(dst_idx), IDX_OFFSET, RATIO_LOG2, N_SRC));
                state_nxt  = QUANT;
            end
            QUANT: state_nxt = SEND;
            SEND: begin
                upd_valid_out = 1'b1;
                if (upd_ready_in) begin
                    if (!en)
                        state_nxt = IDLE;
                    else if (!last_tap || mode_cont)
                        state_nxt = READ;
                    else
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            dst_idx        <= '0;
            err_q          <= '0;
            upd_idx_out    <= '0;
            upd_code_out   <= '0;
            sweep_done_out <= 1'b0;
            sweep_cnt_out  <= '0;
        end else begin
            state          <= state_nxt;
            sweep_done_out <= 1'b0;
            case (state)
                IDLE: if (state_nxt == READ) begin
                    dst_idx <= '0;
                    err_q   <= '0;
                end
                QUANT: begin
                    upd_idx_out  <= dst_idx;
                    upd_code_out <= q_code;
                    if (ns_en) err_q <= q_err;
                end
                SEND: if (upd_ready_in) begin
                    if (!last_tap) begin
                        dst_idx <= dst_idx + DST_W'(1);
                    end else begin
                        dst_idx <= '0;
                        err_q   <= '0;
                        // an abort on the final tap does not count as a sweep
                        if (en) begin
                            sweep_done_out <= 1'b1;
                            sweep_cnt_out  <= sweep_cnt_out + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_w0_coeff_bridge.sv
// Self-checking bench for w0_coeff_bridge with a floor-division reference model.
module tb_w0_coeff_bridge;
    localparam int N_SRC      = 4;
    localparam int N_DST      = 8;
    localparam int IDX_OFFSET = 1;
    localparam int COEFF_W    = 28;
    localparam int R_COEFF    = 20;
    localparam int SHIFT      = 0;
    localparam int CODE_W     = 2;
    localparam int ERR_W      = COEFF_W + 2;
    localparam longint ONE    = longint'(1) << R_COEFF;
    localparam longint E_MAX  = (longint'(1) << (ERR_W - 1)) - 1;
    localparam longint E_MIN  = -(longint'(1) << (ERR_W - 1));
    localparam longint L_MAX  = (longint'(1) << CODE_W) - 1;

    logic               clock = 1'b0;
    logic               reset, en, mode_cont, start, ns_en, upd_ready_in;
    logic               rd_en_out;
    logic [1:0]         rd_idx_out;
    logic [COEFF_W-1:0] rd_coeff_in;
    logic               upd_valid_out;
    logic [2:0]         upd_idx_out;
    logic [1:0]         upd_code_out;
    logic               busy_out, sweep_done_out;
    logic [15:0]        sweep_cnt_out;

    logic signed [COEFF_W-1:0] mem [N_SRC];
    longint tap_val [N_DST];
    int     rd_log [$];
    int     checks = 0;
    int     failures = 0;
    int     exp_cnt = 0;

    w0_coeff_bridge #(
        .N_SRC(N_SRC), .N_DST(N_DST), .IDX_OFFSET(IDX_OFFSET), .COEFF_W(COEFF_W),
        .R_COEFF(R_COEFF), .SHIFT(SHIFT), .CODE_W(CODE_W), .ERR_W(ERR_W)
    ) dut (
        .clock(clock), .reset(reset), .en(en), .mode_cont(mode_cont), .start(start),
        .ns_en(ns_en), .rd_en_out(rd_en_out), .rd_idx_out(rd_idx_out),
        .rd_coeff_in(rd_coeff_in), .upd_valid_out(upd_valid_out),
        .upd_ready_in(upd_ready_in), .upd_idx_out(upd_idx_out),
        .upd_code_out(upd_code_out), .busy_out(busy_out),
        .sweep_done_out(sweep_done_out), .sweep_cnt_out(sweep_cnt_out)
    );

    always #5 clock = ~clock;

    // coefficient memory answers one cycle after the read strobe
    always @(posedge clock) if (rd_en_out) rd_coeff_in <= mem[rd_idx_out];
    always @(negedge clock) if (rd_en_out) rd_log.push_back(int'(rd_idx_out));

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill_mem(input longint v);
        for (int i = 0; i < N_SRC; i++) mem[i] = COEFF_W'(v);
    endtask

    task automatic fill_random();
        logic signed [COEFF_W-1:0] r;
        for (int i = 0; i < N_SRC; i++) begin
            r = COEFF_W'($urandom);
            mem[i] = r >>> $urandom_range(0, 9);
        end
    endtask

    function automatic int exp_src(input int d);
        int s;
        s = (d + IDX_OFFSET) / (N_DST / N_SRC);
        return (s > N_SRC - 1) ? N_SRC - 1 : s;
    endfunction

    // nearest odd level, ties upward, clipped; error saturated
    task automatic model_tap(input longint c, input bit ns, inout longint err, output int code);
        longint v, q, lvl, e;
        v = (c >>> SHIFT) + (ns ? err : 0);
        q = (v >= 0) ? v / (2 * ONE) : -((-v + 2 * ONE - 1) / (2 * ONE));
        lvl = 2 * q + 1;
        if (lvl > L_MAX) lvl = L_MAX;
        if (lvl < -L_MAX) lvl = -L_MAX;
        e = v - lvl * ONE;
        if (e > E_MAX) e = E_MAX;
        if (e < E_MIN) e = E_MIN;
        if (ns) err = e;
        case (lvl)
            -3:      code = 0;
            3:       code = 1;
            -1:      code = 2;
            default: code = 3;
        endcase
    endtask

    task automatic run_sweep(input string name, input bit ns, input int bp_tap, input bit per_tap);
        longint err = 0;
        longint c;
        int code, n;
        rd_log.delete();
        ns_en = ns; mode_cont = 0; en = 1; upd_ready_in = 1;
        if (per_tap) fill_mem(tap_val[0]);
        start = 1;
        @(negedge clock);
        start = 0;
        chk({name, ".read_strobe"}, rd_en_out, 1);
        chk({name, ".busy"}, busy_out, 1);
        chk({name, ".early_valid"}, upd_valid_out, 0);
        for (int d = 0; d < N_DST; d++) begin
            n = 0;
            while (!upd_valid_out && n < 8) begin @(negedge clock); n++; end
            chk({name, ".tap_cycles"}, n, 2);
            c = longint'(mem[exp_src(d)]);
            model_tap(c, ns, err, code);
            chk({name, ".upd_idx"}, upd_idx_out, d);
            chk({name, ".upd_code"}, upd_code_out, code);
            if (d == bp_tap) begin
                upd_ready_in = 0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clock);
                    chk({name, ".stall_valid"}, upd_valid_out, 1);
                    chk({name, ".stall_idx"}, upd_idx_out, d);
                    chk({name, ".stall_code"}, upd_code_out, code);
                    chk({name, ".stall_rd_en"}, rd_en_out, 0);
                end
                upd_ready_in = 1;
            end
            if (per_tap && d < N_DST - 1) fill_mem(tap_val[d + 1]);
            @(negedge clock);
            if (d < N_DST - 1) chk({name, ".early_done"}, sweep_done_out, 0);
        end
        exp_cnt++;
        chk({name, ".done"}, sweep_done_out, 1);
        chk({name, ".idle_after"}, busy_out, 0);
        chk({name, ".sweep_cnt"}, sweep_cnt_out, exp_cnt);
        @(negedge clock);
        chk({name, ".done_pulse"}, sweep_done_out, 0);
        chk({name, ".rd_count"}, rd_log.size(), N_DST);
        for (int i = 0; i < rd_log.size() && i < N_DST; i++)
            chk({name, ".rd_idx"}, rd_log[i], exp_src(i));
    endtask

    initial begin
        int n;
        reset = 1; en = 0; mode_cont = 0; start = 0; ns_en = 0; upd_ready_in = 1;
        fill_mem(0);
        #1;
        chk("reset.rd_en", rd_en_out, 0);
        chk("reset.rd_idx", rd_idx_out, 0);
        chk("reset.valid", upd_valid_out, 0);
        chk("reset.upd_idx", upd_idx_out, 0);
        chk("reset.code", upd_code_out, 0);
        chk("reset.busy", busy_out, 0);
        chk("reset.done", sweep_done_out, 0);
        chk("reset.cnt", sweep_cnt_out, 0);
        repeat (2) @(negedge clock);
        reset = 0;
        en = 1;
        repeat (3) @(negedge clock);
        chk("idle.no_start", busy_out, 0);

        fill_random();
        run_sweep("map", 0, 3, 0);

        tap_val = '{3 * ONE, -3 * ONE, 943718, -1258291, 10 * ONE, 0, ONE / 2, -ONE / 4};
        run_sweep("quant", 0, -1, 1);

        fill_mem(ONE / 4);
        run_sweep("ns", 1, -1, 0);

        fill_random();
        run_sweep("rand_ns", 1, $urandom_range(0, N_DST - 1), 0);
        fill_random();
        run_sweep("rand", 0, $urandom_range(0, N_DST - 1), 0);

        en = 0; start = 1;
        repeat (3) @(negedge clock);
        start = 0;
        chk("start_gated.busy", busy_out, 0);

        fill_random();
        ns_en = 0; upd_ready_in = 1; en = 1; mode_cont = 1;
        n = 0;
        while (!sweep_done_out && n < 60) begin @(negedge clock); n++; end
        chk("cont.first_done", sweep_done_out, 1);
        exp_cnt++;
        chk("cont.cnt1", sweep_cnt_out, exp_cnt);
        n = 0;
        do begin @(negedge clock); n++; end while (!sweep_done_out && n < 60);
        chk("cont.period", n, 3 * N_DST);
        exp_cnt++;
        chk("cont.cnt2", sweep_cnt_out, exp_cnt);
        chk("cont.busy", busy_out, 1);

        n = 0;
        while (!(upd_valid_out && upd_idx_out == 3'd3) && n < 40) begin @(negedge clock); n++; end
        chk("abort.reach_tap", upd_idx_out, 3);
        en = 0;
        @(negedge clock);
        chk("abort.busy", busy_out, 0);
        chk("abort.no_done", sweep_done_out, 0);
        repeat (4) @(negedge clock);
        chk("abort.stays_idle", busy_out, 0);
        chk("abort.cnt", sweep_cnt_out, exp_cnt);

        mode_cont = 0; en = 1; start = 1;
        @(negedge clock);
        start = 0;
        n = 0;
        while (!upd_valid_out && n < 8) begin @(negedge clock); n++; end
        chk("restart.valid", upd_valid_out, 1);
        chk("restart.idx0", upd_idx_out, 0);

        #2 reset = 1;
        #1;
        chk("async_reset.valid", upd_valid_out, 0);
        chk("async_reset.busy", busy_out, 0);
        chk("async_reset.cnt", sweep_cnt_out, 0);
        @(negedge clock);
        reset = 0;
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/w0_coeff_bridge.md
Name: w0_coeff_bridge

Overview:
- Parametrised successor to the hard-wired W1-to-W0 coefficient bridge.
- Sweeps the adaptive filter's coefficients through a read port and maps each destination tap to a source tap.
- Quantises each value to a multi-level odd-integer code with optional first-order error-feedback noise shaping, and writes codes to the W0 LUT over a valid/ready update port.
- Supports single-shot or continuous sweeps, backpressure and clean abort; sits between the LMS-updated W filter and the primary-path W0 LUT.

Parameters:
- N_SRC, 32, number of source (adaptive W) taps; power of two.
- N_DST, 1024, number of destination (W0) taps; power-of-two multiple of N_SRC.
- IDX_OFFSET, 17, added to the destination index before the source mapping shift.
- COEFF_W, 24, source coefficient width, signed.
- R_COEFF, 20, fractional bits of the source coefficient.
- SHIFT, 5, arithmetic right shift applied to the coefficient before quantisation.
- CODE_W, 2, output code width; levels are the odd integers ±1..±(2^CODE_W−1).
- ERR_W, COEFF_W+2, saturating width of the error-feedback register.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  bridge enable
- mode_cont  in  1  1 = continuous sweeps, 0 = single-shot
- start  in  1  single-shot trigger, sampled in IDLE
- ns_en  in  1  enable noise-shaping error feedback
- rd_en_out  out  1  coefficient read strobe
- rd_idx_out  out  $clog2(N_SRC)  source tap index
- rd_coeff_in  in  COEFF_W  coefficient; valid the cycle after rd_en_out
- upd_valid_out  out  1  update valid
- upd_ready_in  in  1  W0 accepts the update
- upd_idx_out  out  $clog2(N_DST)  destination tap index
- upd_code_out  out  CODE_W  quantised level code
- busy_out  out  1  sweep in progress
- sweep_done_out  out  1  one-cycle pulse after the last tap is accepted
- sweep_cnt_out  out  16  completed sweeps, wraps at 2^16

Behaviour:
- Reset (async, active-high) clears all of the following immediately, independent of clock: every output to 0, FSM to IDLE, dst_idx to 0, error register to 0, sweep_cnt to 0.
- FSM states and transitions:
  - IDLE → READ when en && (start || mode_cont). On entry, dst_idx = 0 and error = 0.
  - READ: assert rd_en_out for one cycle with rd_idx_out = min((dst_idx+IDX_OFFSET) >> log2(N_DST/N_SRC), N_SRC−1).
  - QUANT: capture rd_coeff_in and compute the code; register upd_code_out and upd_idx_out, then go to SEND.
  - SEND: upd_valid_out = 1. upd_idx_out and upd_code_out are held stable while !upd_ready_in. On handshake:
    - If dst_idx < N_DST−1: dst_idx++ and go to READ.
    - If this is the last tap: pulse sweep_done_out, sweep_cnt++, then go to READ (dst_idx = 0, error = 0) if en && mode_cont, else go to IDLE.
- Timing:
  - First upd_valid_out is asserted 3 cycles after start is sampled.
  - Throughput is 3 cycles per tap with ready held high.
  - busy_out is high in every state except IDLE.
- Abort: en low is sampled only at the SEND handshake. The current tap completes, then the FSM goes to IDLE without sweep_done_out or a count increment. The next sweep restarts at index 0.
- Quantiser arithmetic:
  - x = rd_coeff_in >>> SHIFT, keeping R_COEFF fractional bits (1.0 = 2^R_COEFF).
  - v = x + (ns_en ? err : 0), computed at ERR_W+1 bits.
  - L = nearest odd integer to v. A tie (v an exact even integer) rounds toward +∞. L is clipped to ±(2^CODE_W−1).
  - err_next = v − L·2^R_COEFF, saturated to ERR_W. The error register updates only when ns_en = 1 and is held otherwise.
- Code mapping:
  - CODE_W = 2 uses the W0 LUT mapping: −3→00, +3→01, −1→10, +1→11.
  - CODE_W > 2 uses offset binary (L+2^CODE_W−1)/2.
- start is ignored outside IDLE. Coefficient reads return live values; no snapshot is taken.

Decomposition:
- Shared package (w0_bridge_pkg): FSM state enum (IDLE, READ, QUANT, SEND), the CODE_W=2 code constants, and an index-mapping function.
- One sub-module, ef_quantizer: combinational nearest-odd quantiser with clip and saturating error output, plus the code encoder. The FSM and counters live in the top.

Test Plan:
- Bench overrides SHIFT=0, R_COEFF=20, N_SRC=4, N_DST=8, IDX_OFFSET=1.
- Index map: single-shot, ready held high → rd_idx sequence 0,1,1,2,2,3,3,3; upd_idx 0..7; one sweep_done pulse; sweep_cnt=1.
- Quantiser, ns_en=0: coefficients 3.0, −3.0, 0.9, −1.2, 10.0, 0.0 → codes 01, 00, 11, 10, 01, 11.
- Noise shaping, ns_en=1, all coefficients 0.25 → levels +1,−1,+1,+1,−1,+1,−1,+1, i.e. codes 11,10,11,11,10,11,10,11; error is 0 after tap 7.
- Backpressure: ready low for 5 cycles in SEND → upd_valid, upd_idx and upd_code stable, no rd_en, dst_idx does not advance; resumes on ready.
- Continuous mode, ready high → sweep_done pulses every 24 cycles. en dropped mid-sweep → current tap completes, busy falls, no pulse. Async reset asserted mid-SEND → upd_valid_out is 0 before the next clock edge.
